pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Drives enable/flush of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use stalls, data-memory wait states and branch/jump redirects resolved in MEM.
- Produces EX-stage forwarding selects and saturating stall/flush performance counters.

Parameters:
FETCH_LAT, 1, extra cycles IF/ID is held flushed after a redirect (instruction-memory latency); legal 0..7
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_rs1 / id_rs2  in  5  source registers of instruction in ID
id_uses_rs1 / id_uses_rs2  in  1  ID instruction reads rs1/rs2
ex_rs1 / ex_rs2  in  5  source registers of instruction in EX
ex_write_reg  in  5  destination of EX instruction
ex_reg_write, ex_mem_reg  in  1  EX instruction writes reg / is a load
mem_write_reg  in  5  destination of MEM instruction
mem_reg_write  in  1  MEM instruction writes reg
mem_redirect  in  1  MEM instruction is a taken branch, jal or jalr
mem_req  in  1  MEM instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
wb_write_reg  in  5  destination of WB instruction
wb_reg_write  in  1  WB instruction writes reg
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load bubble (all-zero control) into register
fwd_a, fwd_b  out  2  EX operand select: 0 regfile, 1 WB result, 2 MEM alu_result
stall_cycles  out  CNT_W  cycles with pc_en=0 outside reset
redirect_count  out  CNT_W  accepted redirects

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high (`reset`).
- State register, FSM states: RUN, MEM_WAIT, REDIRECT. Also a 3-bit bubble counter `bub_cnt`.
- All control outputs are combinational from state and inputs.
- Counters, state and `bub_cnt` update on the posedge of `clk`.
- While reset=1:
  - pc_en=0; all *_en=1; all *_flush=1; fwd_a=fwd_b=0.
  - Next state RUN, bub_cnt=0, both counters 0.
- Default outputs (RUN, no hazard): all *_en=1, all *_flush=0.
- Priority in RUN, highest first: redirect, mem wait, load-use.
- Redirect (mem_redirect=1):
  - pc_en=1 (PC loads target); ifid_flush, idex_flush, exmem_flush=1.
  - redirect_count+1.
  - If FETCH_LAT>0: next state REDIRECT with bub_cnt=FETCH_LAT; otherwise stay in RUN.
  - mem_req is ignored this cycle (mutually exclusive by ISA).
- REDIRECT state:
  - ifid_flush=1; bub_cnt decrements each cycle; return to RUN when bub_cnt reaches 1.
  - A new mem_redirect restarts bub_cnt=FETCH_LAT and counts again.
  - Load-use and mem-wait rules still apply; mem wait overrides ifid_flush (everything frozen).
- Mem wait (mem_req=1 and mem_ready=0):
  - pc_en, ifid_en, idex_en, exmem_en=0; memwb_flush=1. Enter MEM_WAIT.
  - Zero-wait access (mem_ready=1 in the first cycle) causes no stall.
- MEM_WAIT state:
  - Same outputs as mem wait; exit to RUN in the cycle mem_ready=1.
  - In that exit cycle all enables=1 and load-use is evaluated normally.
  - mem_req must remain 1 while waiting; mem_req=0 in MEM_WAIT also returns to RUN (defensive).
- Load-use:
  - Condition: ex_mem_reg & ex_reg_write & ex_write_reg!=0 & ((id_uses_rs1 & id_rs1==ex_write_reg) | (id_uses_rs2 & id_rs2==ex_write_reg)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1. One cycle only; hazard clears as the load advances.
  - Suppressed while mem wait holds ID/EX frozen.
- Forwarding (per operand, applies in every state):
  - Select 2 if mem_reg_write & mem_write_reg!=0 & match.
  - Else select 1 if wb_reg_write & wb_write_reg!=0 & match.
  - Else select 0. MEM takes priority over WB. x0 is never forwarded.
- stall_cycles increments on each non-reset cycle with pc_en=0.
- Both counters saturate at all-ones; no wrap.
- Reset asserted in any state aborts to RUN on the next edge; no residual flush/bubble.

Decomposition:
- pipe_ctrl_pkg: state enum (RUN, MEM_WAIT, REDIRECT); FWD_RF=0, FWD_WB=1, FWD_MEM=2 constants; REG_ZERO=5'd0.
- Sub-module fwd_unit: purely combinational forwarding mux selects; instantiated once per operand.

Test Plan:
- Load x5 in EX, ID add uses rs1=5 → one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle fwd_a=1 when the add reaches EX; stall_cycles=1.
- ex_write_reg=0 load, ID rs1=0 → no stall; MEM writes x0 → fwd_a stays 0.
- mem_req=1, mem_ready low 3 cycles then high → 3 cycles pc_en/ifid/idex/exmem_en=0, memwb_flush=1; stall_cycles=3; RUN after.
- FETCH_LAT=2, mem_redirect pulse → cycle 0: ifid/idex/exmem_flush=1; next 2 cycles ifid_flush=1; redirect_count=1.
- MEM and WB both write x7, EX rs2=7 → fwd_b=2; only WB writes → fwd_b=1.
- reset asserted mid MEM_WAIT → next cycle state RUN, counters 0, enables all 1 with reset low and no hazard.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for a single source register.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic [4:0] mem_write_reg,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_write_reg,
    input  logic       wb_reg_write,
    output logic [1:0] sel
);

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_write_reg != REG_ZERO) && (mem_write_reg == src_reg))
            sel = FWD_MEM;
        else if (wb_reg_write && (wb_write_reg != REG_ZERO) && (wb_write_reg == src_reg))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32 pipeline: stalls,
// flushes, redirect bubbles, forwarding selects and performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_reg_write,
    input  logic             ex_mem_reg,
    input  logic [4:0]       mem_write_reg,
    input  logic             mem_reg_write,
    input  logic             mem_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [4:0]       wb_write_reg,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    ctrl_state_t state;
    logic [2:0]  bub_cnt;
    logic        redirect;
    logic        mem_wait;
    logic        load_use;
    logic        load_use_stall;
    logic [1:0]  fwd_a_raw;
    logic [1:0]  fwd_b_raw;

    fwd_unit u_fwd_a (
        .src_reg       (ex_rs1),
        .mem_write_reg (mem_write_reg),
        .mem_reg_write (mem_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .src_reg       (ex_rs2),
        .mem_write_reg (mem_write_reg),
        .mem_reg_write (mem_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_raw)
    );

    // The same condition both enters and holds MEM_WAIT, so state only matters for bubbles.
    assign redirect = mem_redirect;
    assign mem_wait = !mem_redirect && mem_req && !mem_ready;
    assign load_use = ex_mem_reg && ex_reg_write && (ex_write_reg != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == ex_write_reg)) ||
                       (id_uses_rs2 && (id_rs2 == ex_write_reg)));
    assign load_use_stall = load_use && !redirect && !mem_wait;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else begin
            ifid_flush = (state == REDIRECT);
            if (load_use_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    // A mem wait during redirect bubbles freezes the bubble count rather than dropping it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            bub_cnt        <= 3'd0;
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (redirect && (redirect_count != '1))
                redirect_count <= redirect_count + 1'b1;

            if (redirect) begin
                if (FETCH_LAT > 0) begin
                    state   <= REDIRECT;
                    bub_cnt <= 3'(FETCH_LAT);
                end else begin
                    state   <= RUN;
                    bub_cnt <= 3'd0;
                end
            end else if (mem_wait) begin
                if (state != REDIRECT)
                    state <= MEM_WAIT;
            end else if (state == REDIRECT) begin
                if (bub_cnt <= 3'd1) begin
                    state   <= RUN;
                    bub_cnt <= 3'd0;
                end else begin
                    bub_cnt <= bub_cnt - 3'd1;
                end
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FETCH_LAT=2, 4-bit counters).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_write_reg;
    logic [4:0] mem_write_reg, wb_write_reg;
    logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_reg;
    logic       mem_reg_write, mem_redirect, mem_req, mem_ready, wb_reg_write;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cycles, redirect_count;
    logic [8:0] ctrl;

    int checkCount = 0;
    int failCount  = 0;

    localparam logic [8:0] C_RESET = 9'b0_1111_1111;
    localparam logic [8:0] C_RUN   = 9'b1_1111_0000;
    localparam logic [8:0] C_LU    = 9'b0_0111_0100;
    localparam logic [8:0] C_WAIT  = 9'b0_0001_0001;
    localparam logic [8:0] C_REDIR = 9'b1_1111_1110;
    localparam logic [8:0] C_BUB   = 9'b1_1111_1000;

    pipe_hazard_ctrl #(.FETCH_LAT(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_reg(ex_mem_reg),
        .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
        .mem_redirect(mem_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_write_reg(wb_write_reg), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_write_reg = 5'd0;
        ex_reg_write = 1'b0; ex_mem_reg = 1'b0;
        mem_write_reg = 5'd0; mem_reg_write = 1'b0; mem_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        wb_write_reg = 5'd0; wb_reg_write = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus();
        mem_reg_write = 1'b1; mem_write_reg = 5'd3; ex_rs1 = 5'd3;
        #1;
        checkOutput("reset_ctrl", ctrl, C_RESET);
        checkOutput("reset_fwd_a", fwd_a, 2'd0);
        tick();
        tick();
        checkOutput("reset_stall_cnt", stall_cycles, 4'd0);
        checkOutput("reset_redir_cnt", redirect_count, 4'd0);

        reset = 1'b0;
        applyStimulus();
        #1;
        checkOutput("idle_ctrl", ctrl, C_RUN);

        // Load x5 in EX, add in ID reads rs1=5.
        ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        #1;
        checkOutput("lu_rs1_ctrl", ctrl, C_LU);
        tick();
        applyStimulus();
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        mem_write_reg = 5'd5; mem_reg_write = 1'b1;
        #1;
        checkOutput("lu_bubble_ctrl", ctrl, C_RUN);
        checkOutput("lu_stall_cnt", stall_cycles, 4'd1);
        tick();
        applyStimulus();
        ex_rs1 = 5'd5; wb_write_reg = 5'd5; wb_reg_write = 1'b1;
        #1;
        checkOutput("lu_fwd_a_wb", fwd_a, 2'd1);
        checkOutput("lu_fwd_ctrl", ctrl, C_RUN);

        applyStimulus();
        ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd9;
        id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
        #1;
        checkOutput("lu_unused_rs1", ctrl, C_RUN);
        id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        #1;
        checkOutput("lu_rs2_ctrl", ctrl, C_LU);
        ex_mem_reg = 1'b0;
        #1;
        checkOutput("alu_no_stall", ctrl, C_RUN);
        ex_mem_reg = 1'b1;
        tick();
        applyStimulus();
        #1;
        checkOutput("lu_rs2_stall_cnt", stall_cycles, 4'd2);

        // x0 is never a hazard nor forwarded.
        ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        mem_write_reg = 5'd0; mem_reg_write = 1'b1;
        wb_write_reg = 5'd0; wb_reg_write = 1'b1;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        #1;
        checkOutput("x0_no_stall", ctrl, C_RUN);
        checkOutput("x0_fwd_a", fwd_a, 2'd0);
        checkOutput("x0_fwd_b", fwd_b, 2'd0);

        applyStimulus();
        mem_write_reg = 5'd7; mem_reg_write = 1'b1;
        wb_write_reg = 5'd7; wb_reg_write = 1'b1;
        ex_rs2 = 5'd7; ex_rs1 = 5'd7;
        #1;
        checkOutput("fwd_b_mem_prio", fwd_b, 2'd2);
        checkOutput("fwd_a_mem_prio", fwd_a, 2'd2);
        mem_reg_write = 1'b0;
        #1;
        checkOutput("fwd_b_wb_only", fwd_b, 2'd1);
        wb_write_reg = 5'd8;
        #1;
        checkOutput("fwd_b_none", fwd_b, 2'd0);
        mem_reg_write = 1'b1; mem_write_reg = 5'd6; wb_write_reg = 5'd7; ex_rs1 = 5'd6;
        #1;
        checkOutput("fwd_a_mem_b_wb", {fwd_a, fwd_b}, 4'b10_01);

        // Data memory wait: three not-ready cycles, then ready.
        applyStimulus();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checkOutput("zero_wait_ctrl", ctrl, C_RUN);
        mem_ready = 1'b0;
        #1;
        checkOutput("wait1_ctrl", ctrl, C_WAIT);
        tick();
        ex_mem_reg = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd4;
        id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
        #1;
        checkOutput("wait2_lu_suppressed", ctrl, C_WAIT);
        tick();
        #1;
        checkOutput("wait3_ctrl", ctrl, C_WAIT);
        tick();
        ex_mem_reg = 1'b0;
        mem_ready = 1'b1;
        #1;
        checkOutput("wait_exit_ctrl", ctrl, C_RUN);
        checkOutput("wait_stall_cnt", stall_cycles, 4'd5);
        tick();
        applyStimulus();
        #1;
        checkOutput("after_wait_ctrl", ctrl, C_RUN);
        checkOutput("after_wait_stall_cnt", stall_cycles, 4'd5);

        // Redirect with FETCH_LAT=2; a simultaneous mem wait is ignored.
        mem_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        checkOutput("redir_ctrl", ctrl, C_REDIR);
        tick();
        applyStimulus();
        #1;
        checkOutput("redir_bub1", ctrl, C_BUB);
        checkOutput("redir_cnt1", redirect_count, 4'd1);
        tick();
        #1;
        checkOutput("redir_bub2", ctrl, C_BUB);
        tick();
        #1;
        checkOutput("redir_done", ctrl, C_RUN);
        checkOutput("redir_stall_cnt", stall_cycles, 4'd5);

        // A second redirect during the bubbles restarts the count.
        mem_redirect = 1'b1;
        tick();
        applyStimulus();
        #1;
        checkOutput("restart_bub1", ctrl, C_BUB);
        mem_redirect = 1'b1;
        #1;
        checkOutput("restart_redir_ctrl", ctrl, C_REDIR);
        tick();
        applyStimulus();
        #1;
        checkOutput("restart_bub_a", ctrl, C_BUB);
        tick();
        #1;
        checkOutput("restart_bub_b", ctrl, C_BUB);
        tick();
        #1;
        checkOutput("restart_done", ctrl, C_RUN);
        checkOutput("restart_redir_cnt", redirect_count, 4'd3);

        // Saturation: 5 + 14 stall cycles clamps at 15.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #1;
        checkOutput("stall_saturate", stall_cycles, 4'd15);
        checkOutput("sat_wait_ctrl", ctrl, C_WAIT);

        // Reset in the middle of MEM_WAIT.
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_ctrl", ctrl, C_RESET);
        tick();
        reset = 1'b0;
        applyStimulus();
        #1;
        checkOutput("post_reset_ctrl", ctrl, C_RUN);
        checkOutput("post_reset_stall", stall_cycles, 4'd0);
        checkOutput("post_reset_redir", redirect_count, 4'd0);
        tick();
        #1;
        checkOutput("post_reset_idle", ctrl, C_RUN);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
